shifter_pipe: RTL

SHIFTER_PIPE -- requirements
Module: shifter_pipe

---
 rtl/shifter_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready handshake.
// Define SHIFTER_PIPE_ROTATE_EN to build the rotate path; otherwise ctrl=11 behaves as SRL.
module shifter_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic               cout,
  output logic               busy
);

  localparam int LVL = $clog2(WIDTH);
  localparam int LO  = LVL / 2;

  // Left shifts run as right shifts on bit-reversed data, so one datapath serves every mode.
  function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] d);
    for (int i = 0; i < WIDTH; i++) reverse[i] = d[WIDTH-1-i];
  endfunction

  // Returns {shifted data, last bit shifted out}.
  function automatic logic [WIDTH:0] shr_step(input logic [WIDTH-1:0] d, input logic fill,
                                              input int n);
    shr_step = {(d >> n) | ({WIDTH{fill}} << (WIDTH - n)), d[n-1]};
  endfunction

`ifdef SHIFTER_PIPE_ROTATE_EN
  function automatic logic [WIDTH-1:0] ror_step(input logic [WIDTH-1:0] d, input int n);
    ror_step = (d >> n) | (d << (WIDTH - n));
  endfunction
`endif

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_d;
  logic             s1_lb, s1_sll, s1_fill;
  logic [LO-1:0]    s1_lo;
`ifdef SHIFTER_PIPE_ROTATE_EN
  logic             s1_ror, s1_nz, ror_in;
`endif

  logic             s2_adv;
  logic             sll_in, fill_in, big_in, lb_next, clamp_in;
  logic [WIDTH-1:0] x_in, d_next, d2;
  logic [LVL-1:0]   amt;
  logic             lb2;
  logic [WIDTH-1:0] res_next;
  logic             cout_next;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;
  assign busy      = s1_valid || s2_valid;

  // Stage 1: reversal, big-shift clamp over the full shamt width, high-order levels.
  always_comb begin
    sll_in  = (ctrl == 2'b10);
    fill_in = (ctrl == 2'b01) && a[WIDTH-1];
    big_in  = (shamt >= SHAMT_W'(WIDTH));
    x_in    = sll_in ? reverse(a) : a;
    amt     = shamt[LVL-1:0];
`ifdef SHIFTER_PIPE_ROTATE_EN
    ror_in   = (ctrl == 2'b11);
    clamp_in = big_in && !ror_in;
`else
    clamp_in = big_in;
`endif
    d_next  = x_in;
    lb_next = 1'b0;
    if (clamp_in) begin
      d_next  = {WIDTH{fill_in}};
      lb_next = (shamt == SHAMT_W'(WIDTH)) ? x_in[WIDTH-1] : fill_in;
    end else begin
      for (int k = LO; k < LVL; k++) begin
        if (amt[k]) begin
`ifdef SHIFTER_PIPE_ROTATE_EN
          if (ror_in) d_next = ror_step(d_next, 1 << k);
          else {d_next, lb_next} = shr_step(d_next, fill_in, 1 << k);
`else
          {d_next, lb_next} = shr_step(d_next, fill_in, 1 << k);
`endif
        end
      end
    end
  end

  // Stage 2: low-order levels, un-reversal and carry-out selection.
  always_comb begin
    d2  = s1_d;
    lb2 = s1_lb;
    for (int k = 0; k < LO; k++) begin
      if (s1_lo[k]) begin
`ifdef SHIFTER_PIPE_ROTATE_EN
        if (s1_ror) d2 = ror_step(d2, 1 << k);
        else {d2, lb2} = shr_step(d2, s1_fill, 1 << k);
`else
        {d2, lb2} = shr_step(d2, s1_fill, 1 << k);
`endif
      end
    end
    res_next = s1_sll ? reverse(d2) : d2;
`ifdef SHIFTER_PIPE_ROTATE_EN
    cout_next = s1_ror ? (s1_nz && d2[WIDTH-1]) : lb2;
`else
    cout_next = lb2;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_d     <= '0;
      s1_lb    <= 1'b0;
      s1_sll   <= 1'b0;
      s1_fill  <= 1'b0;
      s1_lo    <= '0;
`ifdef SHIFTER_PIPE_ROTATE_EN
      s1_ror   <= 1'b0;
      s1_nz    <= 1'b0;
`endif
      res      <= '0;
      cout     <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          res  <= res_next;
          cout <= cout_next;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_d    <= d_next;
          s1_lb   <= lb_next;
          s1_sll  <= sll_in;
          s1_fill <= fill_in;
          s1_lo   <= clamp_in ? '0 : amt[LO-1:0];
`ifdef SHIFTER_PIPE_ROTATE_EN
          s1_ror  <= ror_in;
          s1_nz   <= (amt != '0);
`endif
        end
      end
    end
  end

endmodule
